// File: rtl/uart_bridge_pkg.sv
// ---------------------------------------------------------------------------
// uart_bridge_pkg
//   Shared definitions for the uart host bridge: the default character width
//   and the 2-bit encodings of the RX and TX sequencing state machines.
// ---------------------------------------------------------------------------
package uart_bridge_pkg;

    // Character width of the uart core the bridge is paired with.
    localparam int DATA_W_DEFAULT = 8;

    // RX sequencer encodings.
    localparam logic [1:0] RX_IDLE_ENC  = 2'b00;
    localparam logic [1:0] RX_ACK_ENC   = 2'b01;
    localparam logic [1:0] RX_WAIT_ENC  = 2'b10;

    // TX sequencer encodings.
    localparam logic [1:0] TX_IDLE_ENC  = 2'b00;
    localparam logic [1:0] TX_START_ENC = 2'b01;
    localparam logic [1:0] TX_BUSY_ENC  = 2'b10;

    typedef enum logic [1:0] {
        RX_IDLE = RX_IDLE_ENC,
        RX_ACK  = RX_ACK_ENC,
        RX_WAIT = RX_WAIT_ENC
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = TX_IDLE_ENC,
        TX_START = TX_START_ENC,
        TX_BUSY  = TX_BUSY_ENC
    } tx_state_e;

endpackage

// File: rtl/uart_bridge_fifo.sv
// ---------------------------------------------------------------------------
// uart_bridge_fifo
//   Synchronous FIFO used for both bridge directions. The head entry comes
//   straight out of the storage registers, so head is valid whenever empty
//   is low; a pushed entry is visible one cycle after the push edge.
//   Push while full is accepted only if a pop happens in the same cycle;
//   pop while empty is ignored (a simultaneous push still lands).
// Ports
//   clk, rst        clock, synchronous active-high reset
//   push, din       write request and data
//   pop             read request (advances head)
//   full, empty     occupancy flags
//   level           entries held, 0..DEPTH
//   head            oldest entry
// ---------------------------------------------------------------------------
module uart_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_level == FULL_LEVEL);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign head      = r_mem[r_rd_ptr];

    // When full, the slot being written is the one being popped this cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            // Pointers are AW bits wide; DEPTH is a power of two, so they wrap.
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; the level counter
    // already marks every entry invalid, and un-reset arrays map to plain
    // register files or RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_host_bridge.sv
// ---------------------------------------------------------------------------
// uart_host_bridge
//   Buffered adapter between the uart core handshake (rdy/rdy_clr/dout,
//   wr_en/din/tx_busy) and a valid/ready host stream, with RX and TX FIFOs
//   and a sticky RX overflow flag.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   uart_rdy, uart_dout           received character from the uart
//   uart_rdy_clr                  one-cycle acknowledge to the uart
//   uart_tx_busy                  uart transmitter busy
//   uart_wr_en, uart_din          transmit request and character
//   rx_data, rx_valid, rx_ready   host RX stream (RX FIFO head)
//   tx_data, tx_valid, tx_ready   host TX stream (into TX FIFO)
//   rx_overflow, ovf_clr          sticky drop flag and its clear
//   rx_level                      RX FIFO occupancy
//   loopback                      only with UART_BRIDGE_LOOPBACK_EN
// Configuration
//   UART_BRIDGE_LOOPBACK_EN: adds the loopback input; while it is high,
//   received characters are routed into the TX FIFO and the host TX port
//   is closed. Without the macro the RX path always feeds the RX FIFO.
// ---------------------------------------------------------------------------
module uart_host_bridge
    import uart_bridge_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef UART_BRIDGE_LOOPBACK_EN
    input  logic                        loopback,
`endif
    input  logic                        uart_rdy,
    input  logic [DATA_W-1:0]           uart_dout,
    output logic                        uart_rdy_clr,
    input  logic                        uart_tx_busy,
    output logic                        uart_wr_en,
    output logic [DATA_W-1:0]           uart_din,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        rx_overflow,
    input  logic                        ovf_clr,
    output logic [$clog2(RX_DEPTH):0]   rx_level
);

    rx_state_e r_rx_state, w_rx_next;
    tx_state_e r_tx_state, w_tx_next;

    logic              w_rx_capture;
    logic              w_lb;
    logic              w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic              w_lb_push, w_host_push;
    logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [DATA_W-1:0] w_tx_din, w_tx_head;
    logic              w_drop;
    logic [$clog2(TX_DEPTH):0] w_tx_level_unused;

    logic [DATA_W-1:0] r_din;
    logic              r_overflow;

    // ---------------- loopback routing ----------------
`ifdef UART_BRIDGE_LOOPBACK_EN
    // The routing decision is only re-sampled in RX_IDLE so a character in
    // flight keeps the destination it was captured for.
    logic r_lb;
    always_ff @(posedge clk) begin
        if (rst)                        r_lb <= 1'b0;
        else if (r_rx_state == RX_IDLE) r_lb <= loopback;
    end
    assign w_lb = (r_rx_state == RX_IDLE) ? loopback : r_lb;
`else
    assign w_lb = 1'b0;
`endif

    // ---------------- RX sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) r_rx_state <= RX_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_rx_next    = r_rx_state;
        w_rx_capture = 1'b0;
        uart_rdy_clr = 1'b0;
        case (r_rx_state)
            RX_IDLE: if (uart_rdy) begin
                w_rx_capture = 1'b1;
                w_rx_next    = RX_ACK;
            end
            RX_ACK: begin
                uart_rdy_clr = 1'b1;
                w_rx_next    = RX_WAIT;
            end
            // Wait for the uart to drop rdy so one character is taken once.
            RX_WAIT: if (!uart_rdy) w_rx_next = RX_IDLE;
            default: w_rx_next = RX_IDLE;
        endcase
    end

    assign w_rx_push = w_rx_capture && !w_lb;
    assign w_lb_push = w_rx_capture &&  w_lb;
    assign w_rx_pop  = rx_valid && rx_ready;

    // A full FIFO still accepts a character if it is popped the same cycle.
    assign w_drop = (w_rx_push && w_rx_full && !w_rx_pop) ||
                    (w_lb_push && w_tx_full && !w_tx_pop);

    always_ff @(posedge clk) begin
        if (rst)          r_overflow <= 1'b0;
        else if (w_drop)  r_overflow <= 1'b1;   // set beats clear
        else if (ovf_clr) r_overflow <= 1'b0;
    end
    assign rx_overflow = r_overflow;

    uart_bridge_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .din   (uart_dout),
        .pop   (w_rx_pop),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .level (rx_level),
        .head  (rx_data)
    );
    assign rx_valid = !w_rx_empty;

    // ---------------- TX sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) r_tx_state <= TX_IDLE;
        else     r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        case (r_tx_state)
            TX_IDLE: if (!w_tx_empty && !uart_tx_busy) begin
                w_tx_pop  = 1'b1;
                w_tx_next = TX_START;
            end
            // wr_en stays up until the uart reports it has taken the character.
            TX_START: if (uart_tx_busy)  w_tx_next = TX_BUSY;
            TX_BUSY:  if (!uart_tx_busy) w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)           r_din <= '0;
        else if (w_tx_pop) r_din <= w_tx_head;
    end

    assign uart_din   = r_din;
    assign uart_wr_en = (r_tx_state == TX_START);

    // Ready also while full if the sequencer pops this cycle, so a full FIFO
    // can take a push and a pop together without changing level.
    assign tx_ready    = (!w_tx_full || w_tx_pop) && !w_lb;
    assign w_host_push = tx_valid && tx_ready;
    assign w_tx_push   = w_host_push || w_lb_push;
    assign w_tx_din    = w_lb_push ? uart_dout : tx_data;

    uart_bridge_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_push),
        .din   (w_tx_din),
        .pop   (w_tx_pop),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .level (w_tx_level_unused),   // TX occupancy is not exported
        .head  (w_tx_head)
    );

endmodule

// File: tb/tb_uart_host_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_host_bridge
//   Directed bench for uart_host_bridge. Expected RX pops and expected uart
//   transmit characters are queued as stimulus is issued; independent
//   monitors pop and compare when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_uart_host_bridge;

    localparam int DW  = 8;
    localparam int RXD = 16;
    localparam int TXD = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uart_rdy = 1'b0;
    logic [DW-1:0] uart_dout = '0;
    logic          uart_rdy_clr;
    logic          uart_tx_busy;
    logic          uart_wr_en;
    logic [DW-1:0] uart_din;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          rx_overflow;
    logic          ovf_clr = 1'b0;
    logic [$clog2(RXD):0] rx_level;
`ifdef UART_BRIDGE_LOOPBACK_EN
    logic          loopback = 1'b0;
`endif

    logic model_busy = 1'b0;
    logic stall      = 1'b0;
    logic model_en   = 1'b1;
    assign uart_tx_busy = model_busy | stall;

    int n_vec = 0;
    int n_err = 0;
    int rdy_clr_cnt = 0;
    int wr_starts = 0;
    logic [DW-1:0] exp_rx_q[$];
    logic [DW-1:0] exp_tx_q[$];

    always #5 clk = ~clk;

    uart_host_bridge #(.DATA_W(DW), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef UART_BRIDGE_LOOPBACK_EN
        .loopback     (loopback),
`endif
        .uart_rdy     (uart_rdy),
        .uart_dout    (uart_dout),
        .uart_rdy_clr (uart_rdy_clr),
        .uart_tx_busy (uart_tx_busy),
        .uart_wr_en   (uart_wr_en),
        .uart_din     (uart_din),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_overflow  (rx_overflow),
        .ovf_clr      (ovf_clr),
        .rx_level     (rx_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // uart RX model: present a character, hold rdy 4 cycles, then release.
    // clr_now raises ovf_clr in the capture cycle.
    task automatic uart_send(input logic [DW-1:0] c, input logic clr_now = 1'b0);
        uart_dout = c;
        uart_rdy  = 1'b1;
        ovf_clr   = clr_now;
        tick(1);
        ovf_clr   = 1'b0;
        tick(3);
        uart_rdy  = 1'b0;
        tick(2);
    endtask

    // Wait until every queued TX character has gone through the uart model.
    task automatic wait_tx_drain(input int budget);
        int t = 0;
        while ((exp_tx_q.size() != 0 || model_busy || uart_wr_en) && t < budget) begin
            tick(1);
            t++;
        end
        check("tx_drain_in_time", (t < budget), 1);
    endtask

    // acknowledge pulse counter
    always @(negedge clk) if (uart_rdy_clr) rdy_clr_cnt++;

    // RX monitor: every host pop is compared against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid && rx_ready) begin
                if (exp_rx_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rx_unexpected: got 0x%0h, expected no character", rx_data);
                end else begin
                    check("rx_data", rx_data, exp_rx_q.pop_front());
                end
            end
        end
    end

    // uart TX model: takes each wr_en, stays busy 10 cycles, checks din.
    initial begin
        logic [DW-1:0] got;
        forever begin
            @(negedge clk);
            if (model_en && uart_wr_en && !uart_tx_busy) begin
                got = uart_din;
                wr_starts++;
                if (exp_tx_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_unexpected: got 0x%0h, expected no character", got);
                end else begin
                    check("uart_din", got, exp_tx_q.pop_front());
                end
                @(posedge clk);
                #1 model_busy = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    check("din_stable", uart_din, got);
                    if (k >= 1) check("wr_en_dropped", uart_wr_en, 0);
                end
                @(posedge clk);
                #1 model_busy = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int c0;
        int t;

        // ---------------- reset ----------------
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_wr_en", uart_wr_en, 0);
        check("rst_rdy_clr", uart_rdy_clr, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_overflow", rx_overflow, 0);

        // ---------------- single RX character ----------------
        c0 = rdy_clr_cnt;
        uart_send(8'h41);
        check("rdy_clr_pulses", rdy_clr_cnt - c0, 1);
        check("rx_valid_0x41", rx_valid, 1);
        check("rx_data_0x41", rx_data, 8'h41);
        check("rx_level_1", rx_level, 1);
        exp_rx_q.push_back(8'h41);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("rx_level_after_pop", rx_level, 0);
        check("rx_valid_after_pop", rx_valid, 0);

        // ---------------- RX overflow ----------------
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_rx_q.push_back(8'(8'h10 + i));
            uart_send(8'(8'h10 + i));
        end
        check("ovf_level_16", rx_level, 16);
        check("ovf_flag_set", rx_overflow, 1);
        check("ovf_head", rx_data, 8'h10);
        uart_send(8'h99, 1'b1);
        check("ovf_set_wins", rx_overflow, 1);
        check("ovf_level_still_16", rx_level, 16);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", rx_overflow, 0);
        rx_ready = 1'b1;
        t = 0;
        while (rx_valid && t < 40) begin
            tick(1);
            t++;
        end
        rx_ready = 1'b0;
        check("rx_drain_in_time", (t < 40), 1);
        check("rx_scoreboard_empty", exp_rx_q.size(), 0);
        check("rx_level_drained", rx_level, 0);

        // ---------------- TX back-to-back ----------------
        s0 = wr_starts;
        exp_tx_q.push_back(8'h48);
        exp_tx_q.push_back(8'h69);
        tx_valid = 1'b1;
        tx_data  = 8'h48;
        check("tx_ready_first", tx_ready, 1);
        tick(1);
        tx_data  = 8'h69;
        check("tx_ready_second", tx_ready, 1);
        tick(1);
        tx_valid = 1'b0;
        wait_tx_drain(200);
        check("tx_two_sequences", wr_starts - s0, 2);

        // ---------------- TX full with simultaneous push/pop ----------------
        stall = 1'b1;
        tick(1);
        s0 = wr_starts;
        tx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tx_data = 8'(8'h60 + i);
            exp_tx_q.push_back(8'(8'h60 + i));
            tick(1);
        end
        tx_valid = 1'b0;
        check("tx_full_not_ready", tx_ready, 0);
        tick(2);
        stall    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h70;
        exp_tx_q.push_back(8'h70);
        #1;
        check("tx_ready_on_pop", tx_ready, 1);
        tick(1);
        tx_valid = 1'b0;
        check("tx_level_held_16", tx_ready, 0);
        wait_tx_drain(600);
        check("tx_seventeen_sequences", wr_starts - s0, 17);

`ifdef UART_BRIDGE_LOOPBACK_EN
        // ---------------- loopback ----------------
        loopback = 1'b1;
        tick(1);
        check("lb_tx_ready_0", tx_ready, 0);
        s0 = wr_starts;
        exp_tx_q.push_back(8'h5A);
        uart_send(8'h5A);
        check("lb_rx_valid_0", rx_valid, 0);
        wait_tx_drain(100);
        check("lb_one_sequence", wr_starts - s0, 1);
        check("lb_rx_level_0", rx_level, 0);
        loopback = 1'b0;
        tick(2);
`endif

        // ---------------- reset mid-transfer ----------------
        model_en = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h33;
        tick(1);
        tx_valid = 1'b0;
        tick(2);
        check("mid_wr_en_high", uart_wr_en, 1);
        rst = 1'b1;
        tick(1);
        check("mid_wr_en_dropped", uart_wr_en, 0);
        rst = 1'b0;
        tick(1);
        check("mid_tx_ready", tx_ready, 1);
        check("mid_wr_en_stays_low", uart_wr_en, 0);

        check("tx_scoreboard_empty", exp_tx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
